// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single synchronous Memory port.
// Data port (D) has fixed priority over fetch port (F). An anti-starvation
// counter forces F to win after FETCH_MAX_WAIT consecutive lost conflicts.
// Reads return one cycle after the grant and are tagged to the issuing port.
module mem_port_arbiter #(
  parameter int unsigned FETCH_MAX_WAIT = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_req,
  input  logic [15:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [15:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0] MAX_WAIT = 4'(FETCH_MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       pend_f;
  logic       pend_d;
  logic       f_win;

  // Arbitration and memory-side mux; grants are forced low while reset is held
  // so the Memory port is quiet immediately, not only after the next edge.
  always_comb begin
    f_win     = f_req && (!d_req || (wait_cnt == MAX_WAIT));
    f_gnt     = reset && f_win;
    d_gnt     = reset && d_req && !f_win;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Read return: route the Memory data to whichever port issued last cycle.
  always_comb begin
    f_rvalid = pend_f;
    d_rvalid = pend_d;
    f_rdata  = pend_f ? mem_rdata : '0;
    d_rdata  = pend_d ? mem_rdata : '0;
  end

  // Pending-read tags: at most one set, both clear after an idle or write cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_f <= 1'b0;
      pend_d <= 1'b0;
    end else begin
      pend_f <= f_gnt;
      pend_d <= d_gnt && !d_we;
    end
  end

  // Starvation counter: counts edges where F waits behind D, cleared when F wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (f_gnt) begin
      wait_cnt <= '0;
    end else if (f_req && d_gnt && (wait_cnt < MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Saturating statistics counter of cycles with both ports requesting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (f_req && d_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a write-first synchronous memory model.
module tb_mem_port_arbiter;

  localparam int unsigned MAXW = 4;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] conflict_cnt;

  logic        s_f_gnt, s_f_rvalid, s_d_gnt, s_d_rvalid, s_mem_we;
  logic [31:0] s_f_rdata, s_d_rdata, s_mem_wdata;
  logic [15:0] s_mem_addr;
  logic [3:0]  s_conflict_cnt;

  mem_port_arbiter #(.FETCH_MAX_WAIT(MAXW), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter build used only to observe saturation.
  mem_port_arbiter #(.FETCH_MAX_WAIT(MAXW), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(s_f_gnt), .f_rvalid(s_f_rvalid), .f_rdata(s_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(s_d_gnt),
    .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we), .mem_rdata(32'h0),
    .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous, 1-cycle read latency, write-first.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
  end

  typedef struct packed {
    logic        is_f;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] shadow [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          m_wait = 0;
  int          m_conf = 0;
  logic        obs_fg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, check responses and grants at negedge, update model.
  task automatic step(input logic f, input logic [15:0] fa, input logic d, input logic dwe,
                      input logic [15:0] da, input logic [31:0] dwd);
    exp_t e;
    logic ef, ed;
    int   sat_exp;
    f_req = f; f_addr = fa; d_req = d; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("f_rvalid", {31'd0, f_rvalid}, {31'd0, e.is_f});
      check_eq("d_rvalid", {31'd0, d_rvalid}, {31'd0, !e.is_f});
      check_eq("f_rdata", f_rdata, e.is_f ? e.data : 32'h0);
      check_eq("d_rdata", d_rdata, e.is_f ? 32'h0 : e.data);
    end else begin
      check_eq("f_rvalid_idle", {31'd0, f_rvalid}, 32'h0);
      check_eq("d_rvalid_idle", {31'd0, d_rvalid}, 32'h0);
      check_eq("f_rdata_idle", f_rdata, 32'h0);
      check_eq("d_rdata_idle", d_rdata, 32'h0);
    end
    ef = f && (!d || (m_wait == MAXW));
    ed = d && !ef;
    check_eq("f_gnt", {31'd0, f_gnt}, {31'd0, ef});
    check_eq("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
    check_eq("mem_we", {31'd0, mem_we}, {31'd0, ed && dwe});
    check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, ef ? fa : (ed ? da : 16'h0)});
    check_eq("mem_wdata", mem_wdata, ed ? dwd : 32'h0);
    check_eq("conflict_cnt", {16'd0, conflict_cnt}, 32'(m_conf));
    sat_exp = (m_conf > 15) ? 15 : m_conf;
    check_eq("sat_cnt", {28'd0, s_conflict_cnt}, 32'(sat_exp));
    obs_fg = f_gnt;
    if (ef) exp_q.push_back('{is_f: 1'b1, data: shadow[fa]});
    if (ed && !dwe) exp_q.push_back('{is_f: 1'b0, data: shadow[da]});
    if (ed && dwe) shadow[da] = dwd;
    if (ef) m_wait = 0;
    else if (f && ed && m_wait < MAXW) m_wait++;
    if (f && d && m_conf < 65535) m_conf++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_f_gnt", {31'd0, f_gnt}, 32'h0);
    check_eq("rst_f_rvalid", {31'd0, f_rvalid}, 32'h0);
    check_eq("rst_d_rvalid", {31'd0, d_rvalid}, 32'h0);
    check_eq("rst_conflict", {16'd0, conflict_cnt}, 32'h0);
    check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    reset = 1'b1;

    // Load memory through the D port.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0001, 32'hA1A1A1A1);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0002, 32'hB2B2B2B2);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 32'hC3C3C3C3);

    // F alone.
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
    idle();

    // D write then read back.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 32'h12345678);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
    idle();
    check_eq("wr_rd_value", shadow[16'h0020], 32'h12345678);

    // Interleaved pipeline F, D, F.
    step(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 32'h0);
    step(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 32'h0);
    idle();

    // Continuous conflict: D,D,D,D,F repeating; also drives the narrow counter past max.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h0010, 1'b1, 1'b1, 16'(16'h0200 + i), 32'(32'h5000 + i));
      check_eq("starve_pattern", {31'd0, obs_fg}, {31'd0, (i % 5) == 4});
    end
    idle();
    check_eq("conflict_20", {16'd0, conflict_cnt}, 32'd20);
    check_eq("sat_hold", {28'd0, s_conflict_cnt}, 32'h0000000F);

    // Reset mid-read: F granted, reset before the response cycle completes.
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
    reset = 1'b0;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0005; d_wdata = 32'hFFFF0000;
    #1;
    check_eq("arst_f_rvalid", {31'd0, f_rvalid}, 32'h0);
    check_eq("arst_f_rdata", f_rdata, 32'h0);
    check_eq("arst_f_gnt", {31'd0, f_gnt}, 32'h0);
    check_eq("arst_d_gnt", {31'd0, d_gnt}, 32'h0);
    check_eq("arst_mem_we", {31'd0, mem_we}, 32'h0);
    check_eq("arst_mem_addr", {16'd0, mem_addr}, 32'h0);
    check_eq("arst_conflict", {16'd0, conflict_cnt}, 32'h0);
    check_eq("arst_sat", {28'd0, s_conflict_cnt}, 32'h0);
    exp_q.delete();
    m_wait = 0;
    m_conf = 0;
    @(posedge clk);
    #1;
    check_eq("arst_hold_rvalid", {31'd0, f_rvalid}, 32'h0);
    check_eq("arst_hold_conflict", {16'd0, conflict_cnt}, 32'h0);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset = 1'b1;
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
